// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - data-memory arbitration bus bundle
//
// Groups every non-clock/reset signal of dmem_arbiter.
//   slave  : the arbiter side (requests, CPU/requester buses and dm_q in;
//            hold, gnt, muxed dmem bus, rdata and busy out)
//   master : the surrounding system (drives the arbiter inputs, observes outputs)
//
// Signals:
//   req[1:0]        level bus request, bit i from requester i
//   holdACK         CPU acknowledges hold (stalled, not driving memory)
//   cpu_we/a/d      CPU dmem write enable / address / write data
//   m_we[1:0]       requester write enables
//   m_a[63:0]       requester addresses, [31:0] requester 0, [63:32] requester 1
//   m_d[2*wide-1:0] requester write data, low half requester 0
//   dm_q            dmem read data
//   hold            hold request to CPU control
//   gnt[1:0]        one-hot requester grant, 00 = CPU owns the port
//   dm_we/a/d       muxed dmem write enable / address / write data
//   rdata           dm_q broadcast to all masters
//   busy            arbiter not idle
interface dmem_arbiter_if #(
  parameter int wide = 32
);
  logic [1:0]        req;
  logic              holdACK;
  logic              cpu_we;
  logic [31:0]       cpu_a;
  logic [wide-1:0]   cpu_d;
  logic [1:0]        m_we;
  logic [63:0]       m_a;
  logic [2*wide-1:0] m_d;
  logic [wide-1:0]   dm_q;
  logic              hold;
  logic [1:0]        gnt;
  logic              dm_we;
  logic [31:0]       dm_a;
  logic [wide-1:0]   dm_d;
  logic [wide-1:0]   rdata;
  logic              busy;

  modport slave (
    input  req, holdACK, cpu_we, cpu_a, cpu_d, m_we, m_a, m_d, dm_q,
    output hold, gnt, dm_we, dm_a, dm_d, rdata, busy
  );

  modport master (
    output req, holdACK, cpu_we, cpu_a, cpu_d, m_we, m_a, m_d, dm_q,
    input  hold, gnt, dm_we, dm_a, dm_d, rdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between CPU, DMA and COP2 streamer
//
// Purpose:
//   Shares the single data-memory port. A requester is chosen round-robin,
//   the CPU is asked to hold, and once it acknowledges the port is granted
//   for a bounded tenure. Every tenure is followed by a CPU-owned slot.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-low reset (0 = reset, sampled on posedge clk)
//   bus  dmem_arbiter_if.slave (see the interface file for the signal list)
//
// Parameters:
//   wide        dmem data width
//   MAX_TENURE  maximum consecutive granted cycles per tenure (>= 1)
//   CPU_SLOT    cycles the CPU keeps the port between tenures (>= 1)
module dmem_arbiter #(
  parameter int wide       = 32,
  parameter int MAX_TENURE = 16,
  parameter int CPU_SLOT   = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int TW = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam int SW = (CPU_SLOT > 1) ? $clog2(CPU_SLOT) : 1;
  localparam logic [TW-1:0] TEN_LAST  = TW'(MAX_TENURE - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CPU_SLOT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD_REQ,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t          r_state;
  logic            r_hold;
  logic [1:0]      r_gnt;
  logic            r_sel;   // requester latched for the current arbitration
  logic            r_last;  // requester served by the most recent tenure
  logic [TW-1:0]   r_ten;
  logic [SW-1:0]   r_slot;

  logic            w_choice;
  logic            w_sel_req;
  logic            w_dm_we;
  logic [31:0]     w_dm_a;
  logic [wide-1:0] w_dm_d;

  // Single requester wins outright; on a tie the one not served last wins.
  assign w_choice  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_sel_req = bus.req[r_sel];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hold  <= 1'b0;
      r_gnt   <= 2'b00;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_ten   <= '0;
      r_slot  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req != 2'b00) begin
            r_sel   <= w_choice;
            r_hold  <= 1'b1;
            r_state <= S_HOLD_REQ;
          end
        end

        S_HOLD_REQ: begin
          // A withdrawn request wins over a same-cycle acknowledge: there is
          // nothing left to grant.
          if (!w_sel_req) begin
            r_hold  <= 1'b0;
            r_slot  <= '0;
            r_state <= S_RELEASE;
          end else if (bus.holdACK) begin
            r_gnt   <= r_sel ? 2'b10 : 2'b01;
            r_ten   <= '0;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          // holdACK is not watched here: a CPU dropping it mid-grant is a
          // protocol violation and the grant simply carries on.
          if (!w_sel_req || (r_ten == TEN_LAST)) begin
            r_hold  <= 1'b0;
            r_gnt   <= 2'b00;
            r_last  <= r_sel;
            r_slot  <= '0;
            r_state <= S_RELEASE;
          end else begin
            r_ten <= r_ten + 1'b1;
          end
        end

        S_RELEASE: begin
          // CPU-owned slot; new requests are only looked at back in IDLE.
          if (r_slot == SLOT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end

        default: begin
          r_hold  <= 1'b0;
          r_gnt   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The port follows the registered grant only; with gnt==00 (including the
  // HOLD_REQ wait) the CPU keeps driving memory.
  always_comb begin
    w_dm_we = bus.cpu_we;
    w_dm_a  = bus.cpu_a;
    w_dm_d  = bus.cpu_d;
    if (r_gnt[0]) begin
      w_dm_we = bus.m_we[0];
      w_dm_a  = bus.m_a[31:0];
      w_dm_d  = bus.m_d[wide-1:0];
    end else if (r_gnt[1]) begin
      w_dm_we = bus.m_we[1];
      w_dm_a  = bus.m_a[63:32];
      w_dm_d  = bus.m_d[2*wide-1:wide];
    end
  end

  assign bus.hold  = r_hold;
  assign bus.gnt   = r_gnt;
  assign bus.dm_we = w_dm_we;
  assign bus.dm_a  = w_dm_a;
  assign bus.dm_d  = w_dm_d;
  assign bus.rdata = bus.dm_q;
  assign bus.busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic ack_en_a;
  logic ack_a = 1'b0;
  logic ack_b = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.wide(32)) a_if ();
  dmem_arbiter_if #(.wide(32)) b_if ();

  dmem_arbiter #(.wide(32), .MAX_TENURE(4), .CPU_SLOT(2)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  dmem_arbiter #(.wide(32), .MAX_TENURE(16), .CPU_SLOT(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // CPU model: acknowledges hold one cycle after it is requested.
  always @(posedge clk) begin
    ack_a <= ack_en_a & a_if.hold;
    ack_b <= b_if.hold;
  end
  assign a_if.holdACK = ack_a;
  assign b_if.holdACK = ack_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] gv(input bit which);
    return which ? b_if.gnt : a_if.gnt;
  endfunction

  // Counts cycles with no grant, then the length of the grant that follows.
  // Returns sampling the first cycle after that grant.
  task automatic run_grant(input bit which, output logic [1:0] g,
                           output int gap, output int len);
    gap = 0;
    while (gv(which) == 2'b00 && gap < 50) begin
      gap++;
      step();
    end
    g   = gv(which);
    len = 0;
    while (g != 2'b00 && gv(which) == g && len < 50) begin
      len++;
      step();
    end
  endtask

  logic [1:0] g;
  int         gap;
  int         len;

  initial begin
    rst        = 1'b0;
    ack_en_a   = 1'b1;
    a_if.req    = 2'b11;
    a_if.cpu_we = 1'b0;
    a_if.cpu_a  = 32'h0000_1234;
    a_if.cpu_d  = 32'h1111_2222;
    a_if.m_we   = 2'b01;
    a_if.m_a    = {32'h0000_0080, 32'h0000_0040};
    a_if.m_d    = {32'h5555_AAAA, 32'hDEAD_BEEF};
    a_if.dm_q   = 32'hCAFE_0001;
    b_if.req    = 2'b00;
    b_if.cpu_we = 1'b0;
    b_if.cpu_a  = 32'h0000_0300;
    b_if.cpu_d  = 32'h0;
    b_if.m_we   = 2'b10;
    b_if.m_a    = {32'h0000_0900, 32'h0000_0800};
    b_if.m_d    = 64'h0;
    b_if.dm_q   = 32'h0;

    // Reset with both requests high.
    step();
    step();
    chk("rst_hold", a_if.hold, 1'b0);
    chk("rst_gnt", a_if.gnt, 2'b00);
    chk("rst_dm_a", a_if.dm_a, 32'h0000_1234);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_rdata", a_if.rdata, 32'hCAFE_0001);

    // Tie and round-robin with MAX_TENURE=4.
    rst = 1'b1;
    run_grant(1'b0, g, gap, len);
    chk("rr1_gnt", g, 2'b01);
    chk("rr1_gap", gap, 3);
    chk("rr1_len", len, 4);
    chk("rr1_hold_off", a_if.hold, 1'b0);
    run_grant(1'b0, g, gap, len);
    chk("rr2_gnt", g, 2'b10);
    chk("rr2_gap", gap, 5);
    chk("rr2_len", len, 4);
    run_grant(1'b0, g, gap, len);
    chk("rr3_gnt", g, 2'b01);
    chk("rr3_gap", gap, 5);
    chk("rr3_len", len, 4);
    a_if.req = 2'b00;
    step();
    step();
    chk("rr_idle_busy", a_if.busy, 1'b0);

    // Single request: write 0xDEADBEEF to 0x40.
    a_if.req = 2'b01;
    step();
    chk("sr_hold_c1", a_if.hold, 1'b1);
    chk("sr_gnt_c1", a_if.gnt, 2'b00);
    chk("sr_cpu_mux", a_if.dm_a, 32'h0000_1234);
    chk("sr_busy_c1", a_if.busy, 1'b1);
    step();
    chk("sr_gnt_c2", a_if.gnt, 2'b00);
    step();
    chk("sr_gnt_c3", a_if.gnt, 2'b01);
    chk("sr_dm_we", a_if.dm_we, 1'b1);
    chk("sr_dm_a", a_if.dm_a, 32'h0000_0040);
    chk("sr_dm_d", a_if.dm_d, 32'hDEAD_BEEF);
    a_if.req = 2'b00;
    step();
    chk("sr_drop_gnt", a_if.gnt, 2'b00);
    chk("sr_drop_hold", a_if.hold, 1'b0);
    chk("sr_drop_busy0", a_if.busy, 1'b1);
    chk("sr_drop_dm_a", a_if.dm_a, 32'h0000_1234);
    step();
    chk("sr_drop_busy1", a_if.busy, 1'b1);
    step();
    chk("sr_idle", a_if.busy, 1'b0);

    // Withdraw while waiting for an acknowledge that never comes.
    ack_en_a = 1'b0;
    a_if.req = 2'b01;
    step();
    step();
    step();
    chk("wd_wait_hold", a_if.hold, 1'b1);
    chk("wd_wait_gnt", a_if.gnt, 2'b00);
    a_if.req = 2'b00;
    step();
    chk("wd_rel_hold", a_if.hold, 1'b0);
    chk("wd_rel_gnt", a_if.gnt, 2'b00);
    chk("wd_rel_busy", a_if.busy, 1'b1);
    step();
    step();
    chk("wd_idle", a_if.busy, 1'b0);
    ack_en_a = 1'b1;

    // Reset in the middle of a grant to requester 0 (last-served is 0 here).
    a_if.req = 2'b01;
    step();
    step();
    step();
    chk("rm_gnt", a_if.gnt, 2'b01);
    rst = 1'b0;
    step();
    chk("rm_gnt_off", a_if.gnt, 2'b00);
    chk("rm_hold_off", a_if.hold, 1'b0);
    chk("rm_busy", a_if.busy, 1'b0);
    rst = 1'b1;
    a_if.req = 2'b11;
    run_grant(1'b0, g, gap, len);
    chk("rm_tie_gnt", g, 2'b01);
    chk("rm_tie_gap", gap, 3);
    a_if.req = 2'b00;
    step();
    step();

    // Preemption with MAX_TENURE=16.
    b_if.req = 2'b10;
    run_grant(1'b1, g, gap, len);
    chk("pe_gnt", g, 2'b10);
    chk("pe_gap", gap, 3);
    chk("pe_len", len, 16);
    chk("pe_rel_hold0", b_if.hold, 1'b0);
    chk("pe_rel_busy0", b_if.busy, 1'b1);
    step();
    chk("pe_rel_hold1", b_if.hold, 1'b0);
    chk("pe_rel_gnt1", b_if.gnt, 2'b00);
    run_grant(1'b1, g, gap, len);
    chk("pe_regnt", g, 2'b10);
    chk("pe_regap", gap, 4);
    b_if.req = 2'b00;
    step();
    step();
    chk("pe_idle", b_if.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
